// File: rtl/instruction_fetch_memory.sv
// Byte-addressed little-endian instruction memory with a valid/ready fetch port,
// fixed LATENCY response pipeline, byte-wide program-load port and error flags.
module instruction_fetch_memory #(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_BYTES = 256,
  parameter int LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_address,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [ADDR_WIDTH-1:0] resp_address,
  output logic [1:0]            resp_error,
  input  logic                  load_enable,
  input  logic [ADDR_WIDTH-1:0] load_address,
  input  logic [7:0]            load_byte
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

  logic [7:0]            r_mem    [DEPTH_BYTES];
  logic                  r_vld_p  [LATENCY];
  logic [ADDR_WIDTH-1:0] r_addr_p [LATENCY];
  logic [DATA_WIDTH-1:0] r_data_p [LATENCY];
  logic [1:0]            r_err_p  [LATENCY];

  logic                  w_accept;
  logic [ADDR_WIDTH:0]   w_end;
  logic [1:0]            w_err;
  logic [IDX_W-1:0]      w_base;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign req_ready = !load_enable && !reset;
  assign w_accept  = req_valid && req_ready;

  // End address is formed one bit wider so addresses near the top never wrap.
  assign w_end    = {1'b0, req_address} + (ADDR_WIDTH+1)'(BYTES);
  assign w_err[0] = (req_address % ADDR_WIDTH'(BYTES)) != '0;
  assign w_err[1] = w_end > (ADDR_WIDTH+1)'(DEPTH_BYTES);
  assign w_base   = req_address[IDX_W-1:0];

  always_comb begin
    w_rdata = '0;
    if (w_err == 2'b00) begin
      for (int i = 0; i < BYTES; i++) begin
        w_rdata[8*i +: 8] = r_mem[w_base + IDX_W'(i)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_enable && (load_address < ADDR_WIDTH'(DEPTH_BYTES))) begin
      r_mem[load_address[IDX_W-1:0]] <= load_byte;
    end
  end

  // p0: capture at acceptance; later stages shift toward the response port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_vld_p[i] <= 1'b0;
      end
    end else begin
      r_vld_p[0] <= w_accept;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld_p[i] <= r_vld_p[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr_p[0] <= req_address;
      r_data_p[0] <= w_rdata;
      r_err_p[0]  <= w_err;
    end
    for (int i = 1; i < LATENCY; i++) begin
      r_addr_p[i] <= r_addr_p[i-1];
      r_data_p[i] <= r_data_p[i-1];
      r_err_p[i]  <= r_err_p[i-1];
    end
  end

  // Payload is masked by valid so idle cycles never expose stale values.
  assign resp_valid   = r_vld_p[LATENCY-1];
  assign resp_data    = resp_valid ? r_data_p[LATENCY-1] : '0;
  assign resp_address = resp_valid ? r_addr_p[LATENCY-1] : '0;
  assign resp_error   = resp_valid ? r_err_p[LATENCY-1]  : 2'b00;

endmodule

// File: doc/instruction_fetch_memory.md
# instruction_fetch_memory

Parametrised, byte-addressed, little-endian instruction memory with a pipelined valid/ready request port, a fixed configurable read latency, a byte-wide program-load port and per-access error reporting. It sits between the fetch stage (program counter) and decode, replacing the zero-latency combinational instruction store. Contents survive reset and are written only through the load port.

## Interface
- ADDR_WIDTH, 64, width of request and load addresses
- DATA_WIDTH, 32, instruction width in bits; must be a multiple of 8 (BYTES = DATA_WIDTH/8)
- DEPTH_BYTES, 256, byte capacity; valid byte addresses 0..DEPTH_BYTES-1
- LATENCY, 2, cycles from request acceptance to response; must be >= 1
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  fetch request present
- req_ready  output  1  request can be accepted this cycle
- req_address  input  ADDR_WIDTH  byte address of instruction
- resp_valid  output  1  response valid, one-cycle pulse per accepted request
- resp_data  output  DATA_WIDTH  instruction; byte at address A in bits [7:0], A+1 in [15:8], etc.
- resp_address  output  ADDR_WIDTH  echo of the request address
- resp_error  output  2  bit0 misaligned, bit1 out of range
- load_enable  input  1  write one byte this cycle
- load_address  input  ADDR_WIDTH  byte address to write
- load_byte  input  8  data to write

## Operation
- Request accepted on a rising edge when req_valid && req_ready; one acceptance per cycle max, back-to-back allowed.
- req_ready = !load_enable && !reset; loads have priority, so reads and writes never share a cycle.
- Read data is sampled from the byte array at the acceptance edge and carried through a LATENCY-stage shift pipeline of (valid, address, data, error); later loads never alter an in-flight response.
- Misaligned: req_address mod BYTES != 0 → resp_error[0]=1.
- Out of range: req_address + BYTES > DEPTH_BYTES (computed at ADDR_WIDTH+1 bits, no wrap) → resp_error[1]=1.
- Both bits may be set together; if either is set resp_data = 0. No byte is read from outside the array.
- Responses are returned strictly in request order; the response side has no back-pressure.
- Load: when load_enable=1, byte array[load_address] <= load_byte at the rising edge. If load_address >= DEPTH_BYTES, the write is silently dropped.
- The byte array is not cleared by reset. Simulation initial value is 0.

## Timing
- Reset (asynchronous assert, synchronous to clk after deassert): all pipeline valid bits cleared; resp_valid=0, resp_data=0, resp_address=0, resp_error=0; req_ready=0 while reset is high.
- Request accepted at edge k → resp_valid=1 with its data in the cycle following edge k+LATENCY-1. Example: LATENCY=1 gives a response right after edge k.
- resp_valid lasts exactly one cycle per request. With continuous acceptance, resp_valid stays high continuously.
- When resp_valid=0, resp_data, resp_address and resp_error are 0 and do not hold stale values.
- Reset mid-flight: all in-flight requests are discarded and produce no response. The first request after deassert behaves as from idle.
- A load at the same edge as a pending req_valid blocks that request; the requester holds req_valid and req_address until accepted.

## Test plan
- Load bytes E5 03 1F 8B at 0..3, then request 0 with LATENCY=2 → resp_valid exactly 2 cycles after acceptance, resp_data=32'h8B1F03E5, resp_error=00.
- Back-to-back requests 0, 4, 8 (contents preloaded) → three consecutive resp_valid cycles in order, resp_address 0, 4, 8, correct data for each.
- Request 2 → resp_error=01, data 0. Request 254 (DEPTH_BYTES=256) → error=11. Request 256 → error=10. Request 2^64-4 → error=10 (no wrap).
- Hold req_valid while load_enable=1 for 3 cycles → req_ready=0 throughout, no acceptance. Then the request is accepted and returns the newly loaded bytes. A load to address 300 leaves the memory unchanged.
- Accept request at 0, then on the next edge load a new byte at 0 → response carries the old data.
- Assert reset asynchronously with 2 requests in flight → resp_valid=0 immediately and no response after release. Memory contents are still readable afterwards.
